blockram_param: RTL and testbench
=================================

BLOCKRAM_PARAM -- requirements
Module: blockram_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 32.
REQ-002 Parameter ADDR_WIDTH, default 8: word address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Ports SHALL be as follows, with one clock and an asynchronous, active-low reset:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- clear_req  in  1  pulse; requests a full memory clear
- init_busy  out  1  high while a clear is in progress
- wr_en  in  1  write strobe, active high
- wr_addr  in  ADDR_WIDTH  write word address
- wr_lane  in  2  sub-word select for narrow writes
- wr_mode  in  2  0=full, 1=half, 2=quarter, 3=full
- wr_data  in  DATA_WIDTH  write data; narrow writes use the low bits
- rd_en  in  1  read strobe, active high
- rd_addr  in  ADDR_WIDTH  read word address
- rd_lane  in  2  sub-word select for narrow reads
- rd_mode  in  2  encoded as wr_mode
- out_reg_en  in  1  adds an output register stage; quasi-static
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data is valid this cycle

Function
REQ-004 FSM SHALL have 2 states, INIT and IDLE; reset enters INIT with an internal clear counter at 0.
REQ-005 INIT SHALL write zero to word[counter] each cycle and increment the counter; after writing word DEPTH-1 it SHALL move to IDLE, giving exactly DEPTH cycles.
REQ-006 init_busy SHALL be 1 exactly while in INIT; wr_en, rd_en and clear_req SHALL be ignored in INIT, and rd_valid SHALL stay 0 for reads issued during INIT.
REQ-007 clear_req=1 in IDLE SHALL enter INIT on the next edge with the counter at 0; a write in the same cycle SHALL be dropped, and a read in the same cycle SHALL complete normally.
REQ-008 Unit sizes: full = DATA_WIDTH bits; half = DATA_WIDTH/2 bits, selected by lane[0]; quarter = DATA_WIDTH/4 bits, selected by lane[1:0]; lane 0 is the LSBs.
REQ-009 A write SHALL store wr_data[unit-1:0] into only the selected unit of word[wr_addr]; all other bits of that word SHALL be unchanged.
REQ-010 Read stage 1: on rd_en in IDLE, SHALL register mem[rd_addr], rd_mode and rd_lane.
REQ-011 Read stage 2: SHALL place the selected unit in the LSBs of rd_data and zero all upper bits; mode 3 is treated as full.
REQ-012 Read latency, rd_en edge to rd_valid=1, SHALL be 1 cycle when out_reg_en=0 and 2 cycles when out_reg_en=1; rd_valid SHALL be a single-cycle pulse per read.
REQ-013 Back-to-back reads SHALL sustain 1 read per cycle in both latencies.
REQ-014 rd_data SHALL hold its last value while rd_valid=0.
REQ-015 A write and a read to different addresses in the same cycle SHALL both complete.
REQ-016 Read-during-write at the same address in the same cycle SHALL follow REQ-022.
REQ-017 Address arithmetic SHALL be modulo DEPTH; no out-of-range access is possible.
REQ-018 A change of out_reg_en while a read is in flight is undefined; the bench SHALL hold it stable.

Reset
REQ-019 While rst_n=0: rd_data=0, rd_valid=0, init_busy=1, FSM=INIT, counter=0, and all read pipeline valids cleared.
REQ-020 Reset asserted mid-clear or mid-read SHALL abort the operation; after release the clear SHALL restart from word 0 and take DEPTH cycles.
REQ-021 Memory array contents are not reset directly; they are zeroed only by the INIT sweep.

Configuration
REQ-022 Macro BLOCKRAM_PARAM_RDW_BYPASS_EN controls read-during-write behaviour at the same address in the same cycle:
- defined: the read SHALL return the new word, i.e. the written unit merged into the old word.
- undefined: the read SHALL return the old word.
- all other behaviour SHALL be identical in both builds.

Verification
REQ-023 Release rst_n, then rd_en to address 0xFF in the first IDLE cycle -> init_busy high for exactly 256 cycles; rd_data=0x00000000 with rd_valid one cycle after rd_en.
REQ-024 Full write 0xDEADBEEF to address 5; quarter write 0xAA with lane 2 to address 5; full read of address 5, once with out_reg_en=0 and once with out_reg_en=1 -> 0xDEAABEEF, rd_valid at +1 and +2 respectively.
REQ-025 Half read with lane 1 of address 5 -> rd_data=0x0000DEAA; quarter read with lane 3 -> 0x000000DE.
REQ-026 Same-cycle full write of 0x12345678 and read of address 9, previously 0 -> 0x12345678 with the macro defined, 0x00000000 without; a following read returns 0x12345678 in both builds.
REQ-027 Write 0x1 to address 3; clear_req pulse together with wr_en to address 4 -> 256 busy cycles; reads of addresses 3 and 4 return 0.
REQ-028 Assert rst_n=0 at clear count 100 -> outputs reach reset values immediately; after release init_busy stays high for a full 256 cycles.

Source files
------------

// File: rtl/blockram_param.sv
// Parameterised block RAM with self-clearing INIT sweep and sub-word access.
// Optional macro BLOCKRAM_PARAM_RDW_BYPASS_EN: same-address read-during-write returns new data.
module blockram_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0]            wr_lane,
  input  logic [1:0]            wr_mode,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]            rd_lane,
  input  logic [1:0]            rd_mode,
  input  logic                  out_reg_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int H     = DATA_WIDTH / 2;
  localparam int Q     = DATA_WIDTH / 4;
  localparam int SW    = $clog2(DATA_WIDTH);

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0]   wr_mask, wr_bits, wr_merged;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    s1_vld_q;
  logic [DATA_WIDTH-1:0]   s1_word_q;
  logic [1:0]              s1_mode_q, s1_lane_q;
  logic [DATA_WIDTH-1:0]   sel;
  logic                    out_vld_q;
  logic [DATA_WIDTH-1:0]   out_q;

  // Low-aligned mask of the unit selected by a mode (mode 3 acts as full).
  function automatic logic [DATA_WIDTH-1:0] unit_mask(input logic [1:0] mode);
    unique case (mode)
      2'd1:    unit_mask = {{(DATA_WIDTH-H){1'b0}}, {H{1'b1}}};
      2'd2:    unit_mask = {{(DATA_WIDTH-Q){1'b0}}, {Q{1'b1}}};
      default: unit_mask = '1;
    endcase
  endfunction

  // Bit offset of the selected unit inside the word.
  function automatic logic [SW-1:0] unit_shamt(input logic [1:0] mode,
                                               input logic [1:0] lane);
    unique case (mode)
      2'd1:    unit_shamt = lane[0] ? SW'(H) : '0;
      2'd2:    unit_shamt = SW'(Q) * SW'(lane);
      default: unit_shamt = '0;
    endcase
  endfunction

  assign init_busy = (state_q == INIT);
  assign wr_fire   = (state_q == IDLE) && wr_en && !clear_req;
  assign rd_fire   = (state_q == IDLE) && rd_en;

  // Next state: sweep in INIT, restart the sweep on a clear request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // FSM state and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Merge the narrow write unit into the currently stored word.
  always_comb begin
    wr_mask   = unit_mask(wr_mode) << unit_shamt(wr_mode, wr_lane);
    wr_bits   = (wr_data & unit_mask(wr_mode))
                << unit_shamt(wr_mode, wr_lane);
    wr_merged = (mem[wr_addr] & ~wr_mask) | wr_bits;
  end

  // Word seen by the read port, with optional same-address bypass.
  always_comb begin
`ifdef BLOCKRAM_PARAM_RDW_BYPASS_EN
    if (wr_fire && (wr_addr == rd_addr)) rd_word = wr_merged;
    else                                 rd_word = mem[rd_addr];
`else
    rd_word = mem[rd_addr];
`endif
  end

  // Array is never reset; only the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == INIT)  mem[cnt_q]   <= '0;
    else if (wr_fire)     mem[wr_addr] <= wr_merged;
  end

  // Read stage 1: capture word and selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_word_q <= '0;
      s1_mode_q <= '0;
      s1_lane_q <= '0;
    end else begin
      s1_vld_q <= rd_fire;
      if (rd_fire) begin
        s1_word_q <= rd_word;
        s1_mode_q <= rd_mode;
        s1_lane_q <= rd_lane;
      end
    end
  end

  // Read stage 2: unit extraction, right-aligned and zero-extended.
  always_comb begin
    sel = (s1_word_q >> unit_shamt(s1_mode_q, s1_lane_q))
          & unit_mask(s1_mode_q);
  end

  // Optional output register; only loads on a valid read so data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) out_q <= sel;
    end
  end

  assign rd_data  = out_reg_en ? out_q     : sel;
  assign rd_valid = out_reg_en ? out_vld_q : s1_vld_q;

endmodule

// File: tb/tb_blockram_param.sv
// Directed bench for blockram_param.
// Expected values are hand-computed constants.
module tb_blockram_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        init_busy;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_lane;
  logic [1:0]  wr_mode;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_lane;
  logic [1:0]  rd_mode;
  logic        out_reg_en;
  logic [31:0] rd_data;
  logic        rd_valid;

  int checks   = 0;
  int failures = 0;
  int n;
  bit sawv;
  logic [31:0] exp_rdw;

  blockram_param dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .init_busy  (init_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_lane    (wr_lane),
    .wr_mode    (wr_mode),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_lane    (rd_lane),
    .rd_mode    (rd_mode),
    .out_reg_en (out_reg_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] m,
                    input logic [1:0] l, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_mode = m; wr_lane = l; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [1:0] m, input logic [1:0] l,
                    input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a; rd_mode = m; rd_lane = l;
    tick();
    rd_en = 1'b0;
    if (out_reg_en) begin
      chk({tag, "_v1"}, {31'd0, rd_valid}, 32'd0);
      tick();
    end
    chk({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
    chk({tag, "_dat"}, rd_data, exp);
    tick();
    chk({tag, "_end"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_hold"}, rd_data, exp);
  endtask

  task automatic count_busy(input string tag);
    n = 0;
    while (init_busy && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, n, 32'd256);
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; out_reg_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_lane = '0; wr_mode = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_lane = '0; rd_mode = '0;
    repeat (3) tick();
    chk("rst_data", rd_data, 32'd0);
    chk("rst_vld", {31'd0, rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);

    rst_n = 1'b1;
    count_busy("init_cycles");

    rd("rd_ff", 8'hFF, 2'd0, 2'd0, 32'h0000_0000);

    wr(8'd5, 2'd0, 2'd0, 32'hDEAD_BEEF);
    wr(8'd5, 2'd2, 2'd2, 32'hFFFF_FFAA);
    rd("full_l1", 8'd5, 2'd0, 2'd0, 32'hDEAA_BEEF);
    out_reg_en = 1'b1;
    rd("full_l2", 8'd5, 2'd0, 2'd0, 32'hDEAA_BEEF);
    out_reg_en = 1'b0;
    rd("half1", 8'd5, 2'd1, 2'd1, 32'h0000_DEAA);
    rd("half0", 8'd5, 2'd1, 2'd0, 32'h0000_BEEF);
    rd("qtr3", 8'd5, 2'd2, 2'd3, 32'h0000_00DE);
    rd("qtr0", 8'd5, 2'd2, 2'd0, 32'h0000_00EF);
    rd("mode3", 8'd5, 2'd3, 2'd2, 32'hDEAA_BEEF);

    wr(8'd7, 2'd1, 2'd1, 32'h1234_5678);
    rd("halfwr", 8'd7, 2'd0, 2'd0, 32'h5678_0000);

`ifdef BLOCKRAM_PARAM_RDW_BYPASS_EN
    exp_rdw = 32'h1234_5678;
`else
    exp_rdw = 32'h0000_0000;
`endif
    wr_en = 1'b1; wr_addr = 8'd9; wr_mode = 2'd0; wr_data = 32'h1234_5678;
    rd_en = 1'b1; rd_addr = 8'd9; rd_mode = 2'd0; rd_lane = 2'd0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_vld", {31'd0, rd_valid}, 32'd1);
    chk("rdw_dat", rd_data, exp_rdw);
    tick();
    rd("rdw_after", 8'd9, 2'd0, 2'd0, 32'h1234_5678);

    wr_en = 1'b1; wr_addr = 8'd10; wr_mode = 2'd0; wr_data = 32'hCAFE_F00D;
    rd_en = 1'b1; rd_addr = 8'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_rd_diff", rd_data, 32'hDEAA_BEEF);
    tick();
    rd("rd10", 8'd10, 2'd0, 2'd0, 32'hCAFE_F00D);

    rd_en = 1'b1; rd_addr = 8'd5; rd_mode = 2'd0;
    tick();
    chk("b2b_a", rd_data, 32'hDEAA_BEEF);
    rd_addr = 8'd9;
    tick();
    rd_en = 1'b0;
    chk("b2b_b", rd_data, 32'h1234_5678);
    chk("b2b_bv", {31'd0, rd_valid}, 32'd1);
    tick();
    chk("b2b_end", {31'd0, rd_valid}, 32'd0);

    out_reg_en = 1'b1;
    rd_en = 1'b1; rd_addr = 8'd10;
    tick();
    rd_addr = 8'd7;
    tick();
    rd_en = 1'b0;
    chk("b2b2_a", rd_data, 32'hCAFE_F00D);
    tick();
    chk("b2b2_b", rd_data, 32'h5678_0000);
    chk("b2b2_bv", {31'd0, rd_valid}, 32'd1);
    tick();
    chk("b2b2_end", {31'd0, rd_valid}, 32'd0);
    out_reg_en = 1'b0;

    wr(8'd3, 2'd0, 2'd0, 32'h0000_0001);
    clear_req = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd4; wr_mode = 2'd0; wr_data = 32'hFFFF_FFFF;
    rd_en = 1'b1; rd_addr = 8'd5;
    tick();
    chk("clr_rd", rd_data, 32'hDEAA_BEEF);
    chk("clr_busy", {31'd0, init_busy}, 32'd1);
    wr_addr = 8'd6;
    sawv = 1'b0;
    n = 0;
    while (init_busy && n < 1000) begin
      tick();
      n++;
      if (rd_valid) sawv = 1'b1;
    end
    clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("clr_cycles", n, 32'd256);
    chk("init_no_vld", {31'd0, sawv}, 32'd0);
    chk("init_hold", rd_data, 32'hDEAA_BEEF);
    tick();
    rd("clr3", 8'd3, 2'd0, 2'd0, 32'h0);
    rd("clr4", 8'd4, 2'd0, 2'd0, 32'h0);
    rd("clr6", 8'd6, 2'd0, 2'd0, 32'h0);

    wr(8'd5, 2'd0, 2'd0, 32'hA5A5_5A5A);
    clear_req = 1'b1;
    rd_en = 1'b1; rd_addr = 8'd5;
    tick();
    clear_req = 1'b0; rd_en = 1'b0;
    chk("c2_rd", rd_data, 32'hA5A5_5A5A);
    repeat (100) tick();
    chk("c2_mid", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_data", rd_data, 32'd0);
    chk("arst_vld", {31'd0, rd_valid}, 32'd0);
    chk("arst_busy", {31'd0, init_busy}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    count_busy("rerun_cycles");
    rd("post_rst", 8'd5, 2'd0, 2'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
